// File: rtl/dna_loader.sv
// Packs a 2-bit nucleotide stream into 16-bit words (8 per word) and writes them to sequence memory.
// Latency: a word write appears one cycle after its filling handshake; ready pulses two cycles after the last handshake.
// Backpressure: nuc_ready is high only while loading; the stream stalls in IDLE, FINAL, NOTIFY and ERR.
module dna_loader #(
    parameter int MAX_NUC = 4096,
    parameter int ADDR_W  = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        nuc_in,
    input  logic              nuc_valid,
    input  logic              nuc_last,
    output logic              nuc_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [15:0]       dna_length,
    output logic              ready,
    output logic              busy,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FINAL,
        S_NOTIFY,
        S_ERR
    } state_t;

    // Index of the last nucleotide that fits; accepting it without nuc_last overflows.
    localparam logic [15:0] LAST_IDX = 16'(MAX_NUC - 1);

    state_t              state_q;
    logic [15:0]         cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         pack_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [15:0]         mem_wdata_q;
    logic [15:0]         dna_length_q;
    logic                ready_q;
    logic                busy_q;
    logic                error_q;

    logic                hs;
    logic [2:0]          slot;
    logic [15:0]         pack_d;
    logic [15:0]         cnt_d;

    assign nuc_ready  = (state_q == S_LOAD);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign dna_length = dna_length_q;
    assign ready      = ready_q;
    assign busy       = busy_q;
    assign error      = error_q;

    // Handshake qualification and the word as it looks once the current nucleotide is merged in.
    always_comb begin
        hs     = nuc_valid && nuc_ready;
        slot   = cnt_q[2:0];
        pack_d = pack_q | (16'(nuc_in) << {slot, 1'b0});
        cnt_d  = cnt_q + 16'd1;
    end

    // Load FSM with all outputs registered; write strobe and ready default low every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            pack_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            dna_length_q <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            ready_q  <= 1'b0;
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        cnt_q   <= '0;
                        addr_q  <= '0;
                        pack_q  <= '0;
                        busy_q  <= 1'b1;
                        error_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        cnt_q <= cnt_d;
                        if (nuc_last) begin
                            // Flush the (possibly partial) word exactly once, even if slot 7 was just filled.
                            state_q     <= S_FINAL;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= addr_q;
                            mem_wdata_q <= pack_d;
                            pack_q      <= '0;
                        end else if (slot == 3'd7) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= addr_q;
                            mem_wdata_q <= pack_d;
                            pack_q      <= '0;
                            addr_q      <= addr_q + 1'b1;
                            // MAX_NUC is a multiple of 8, so overflow always coincides with a full word.
                            if (cnt_q == LAST_IDX) begin
                                state_q <= S_ERR;
                                error_q <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            pack_q <= pack_d;
                        end
                    end
                end
                S_FINAL: begin
                    dna_length_q <= cnt_q;
                    ready_q      <= 1'b1;
                    state_q      <= S_NOTIFY;
                end
                S_NOTIFY: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dna_loader.sv
// Directed/randomized bench for dna_loader: one default-sized instance and one with MAX_NUC=16 share stimulus.
// Expected memory words are rebuilt from the accepted nucleotide list; write and ready events are logged by a monitor.
// All waits are bounded; the run always ends with the summary line.
module tb_dna_loader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, start, nuc_valid, nuc_last;
    logic [1:0] nuc_in;

    logic        a_nuc_ready, a_mem_we, a_ready, a_busy, a_error;
    logic [8:0]  a_mem_addr;
    logic [15:0] a_mem_wdata, a_dna_length;

    logic        b_nuc_ready, b_mem_we, b_ready, b_busy, b_error;
    logic [0:0]  b_mem_addr;
    logic [15:0] b_mem_wdata, b_dna_length;

    dna_loader #(.MAX_NUC(4096), .ADDR_W(9)) u_a (
        .clock(clock), .reset(reset), .start(start), .nuc_in(nuc_in),
        .nuc_valid(nuc_valid), .nuc_last(nuc_last), .nuc_ready(a_nuc_ready),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .dna_length(a_dna_length), .ready(a_ready), .busy(a_busy), .error(a_error)
    );

    dna_loader #(.MAX_NUC(16), .ADDR_W(1)) u_b (
        .clock(clock), .reset(reset), .start(start), .nuc_in(nuc_in),
        .nuc_valid(nuc_valid), .nuc_last(nuc_last), .nuc_ready(b_nuc_ready),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .dna_length(b_dna_length), .ready(b_ready), .busy(b_busy), .error(b_error)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Event log written only by the monitor.
    int          wa_n = 0, wb_n = 0, ra_n = 0, rb_n = 0;
    logic [8:0]  wa_addr [0:1023];
    logic [15:0] wa_data [0:1023];
    logic [0:0]  wb_addr [0:1023];
    logic [15:0] wb_data [0:1023];

    always @(negedge clock) begin
        if (a_mem_we && wa_n < 1024) begin
            wa_addr[wa_n] = a_mem_addr;
            wa_data[wa_n] = a_mem_wdata;
            wa_n++;
        end
        if (b_mem_we && wb_n < 1024) begin
            wb_addr[wb_n] = b_mem_addr;
            wb_data[wb_n] = b_mem_wdata;
            wb_n++;
        end
        if (a_ready) ra_n++;
        if (b_ready) rb_n++;
    end

    logic [1:0] seq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word w of the memory image: nucleotide k lives at bits 2*(k mod 8) of word k/8, unused bits zero.
    function automatic logic [15:0] exp_word(input int w);
        logic [15:0] word = 16'h0;
        for (int k = w * 8; k < seq.size() && k < w * 8 + 8; k++)
            word = word | (16'(seq[k]) << (2 * (k % 8)));
        return word;
    endfunction

    task automatic check_zero_a(input string tag);
        check({tag, "_ctrl"}, {27'd0, a_nuc_ready, a_mem_we, a_ready, a_busy, a_error}, 32'd0);
        check({tag, "_addr"}, {23'd0, a_mem_addr}, 32'd0);
        check({tag, "_wdata"}, {16'd0, a_mem_wdata}, 32'd0);
        check({tag, "_len"}, {16'd0, a_dna_length}, 32'd0);
    endtask

    task automatic check_writes(input string tag, input int base, input bit use_b);
        int nwords = (seq.size() + 7) / 8;
        int got    = use_b ? (wb_n - base) : (wa_n - base);
        check({tag, "_nwrites"}, got, nwords);
        for (int i = 0; i < nwords && i < got; i++) begin
            check($sformatf("%s_addr%0d", tag, i),
                  use_b ? {31'd0, wb_addr[base+i]} : {23'd0, wa_addr[base+i]}, i);
            check($sformatf("%s_data%0d", tag, i),
                  use_b ? {16'd0, wb_data[base+i]} : {16'd0, wa_data[base+i]}, {16'd0, exp_word(i)});
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Offer seq one nucleotide at a time until each has been accepted by the selected instance.
    task automatic send(input bit use_b, input bit with_last, input bit gaps, input bit hold_start);
        int   idx = 0;
        int   budget = 0;
        logic rdy;
        while (idx < seq.size() && budget < 2000) begin
            nuc_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            nuc_in    = seq[idx];
            nuc_last  = with_last && (idx == seq.size() - 1);
            start     = hold_start;
            @(negedge clock);
            rdy = use_b ? b_nuc_ready : a_nuc_ready;
            @(posedge clock); #1;
            if (nuc_valid && rdy) idx++;
            budget++;
        end
        nuc_valid = 1'b0;
        nuc_last  = 1'b0;
        check("send_accepted", idx, seq.size());
    endtask

    // Full load on the default instance with last, checking flush, ready timing, length and memory image.
    task automatic run_load(input string tag, input bit gaps, input bit hold_start);
        int base = wa_n;
        int r0   = ra_n;
        pulse_start();
        send(1'b0, 1'b1, gaps, hold_start);
        @(negedge clock);
        check({tag, "_final_we"}, {31'd0, a_mem_we}, 32'd1);
        check({tag, "_final_rdy"}, {31'd0, a_ready}, 32'd0);
        @(negedge clock);
        check({tag, "_notify_rdy"}, {31'd0, a_ready}, 32'd1);
        check({tag, "_len"}, {16'd0, a_dna_length}, seq.size());
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        check({tag, "_idle_busy"}, {30'd0, a_busy, a_ready}, 32'd0);
        check({tag, "_len_hold"}, {16'd0, a_dna_length}, seq.size());
        check({tag, "_rdy_pulses"}, ra_n - r0, 1);
        check_writes(tag, base, 1'b0);
    endtask

    initial begin
        int base;
        int r0;
        reset = 1'b1; start = 1'b0; nuc_valid = 1'b0; nuc_last = 1'b0; nuc_in = 2'b00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_zero_a("rst");
        check("rst_b", {b_nuc_ready, b_mem_we, b_ready, b_busy, b_error}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // All A except nucleotide 15 = T, last on 16th.
        seq.delete();
        for (int i = 0; i < 15; i++) seq.push_back(2'b00);
        seq.push_back(2'b11);
        base = wa_n;
        run_load("s1", 1'b0, 1'b0);
        check("s1_w0", {16'd0, wa_data[base]}, 32'h0000);
        check("s1_w1", {16'd0, wa_data[base+1]}, 32'hC000);

        // 45 random nucleotides, then the same stream with valid gaps.
        seq.delete();
        for (int i = 0; i < 45; i++) seq.push_back(2'($urandom_range(0, 3)));
        base = wa_n;
        run_load("s2", 1'b0, 1'b0);
        check("s2_w5_pad", {26'd0, wa_data[base+5][15:10]}, 32'd0);
        run_load("s3", 1'b1, 1'b0);

        // Overflow on the MAX_NUC=16 instance.
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        seq.delete();
        for (int i = 0; i < 16; i++) seq.push_back(2'($urandom_range(0, 3)));
        base = wb_n;
        r0   = rb_n;
        pulse_start();
        send(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("s4_error", {31'd0, b_error}, 32'd1);
        check("s4_nrdy", {30'd0, b_nuc_ready, b_busy}, 32'd0);
        repeat (3) @(negedge clock);
        check("s4_error_hold", {31'd0, b_error}, 32'd1);
        check("s4_len", {16'd0, b_dna_length}, 32'd0);
        check("s4_no_ready", rb_n - r0, 0);
        check_writes("s4", base, 1'b1);
        @(posedge clock); #1;
        pulse_start();
        @(negedge clock);
        check("s4_restart", {30'd0, b_error, b_busy}, 32'd1);

        // Reset after 5 handshakes discards the partial word.
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        seq.delete();
        for (int i = 0; i < 5; i++) seq.push_back(2'($urandom_range(1, 3)));
        pulse_start();
        send(1'b0, 1'b0, 1'b0, 1'b0);
        base = wa_n;
        r0   = ra_n;
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check_zero_a("s5_rst");
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("s5_no_write", wa_n - base, 0);
        check("s5_no_ready", ra_n - r0, 0);
        @(posedge clock); #1;
        seq.delete();
        seq.push_back(2'b10);
        base = wa_n;
        run_load("s5", 1'b0, 1'b0);
        check("s5_w0", {16'd0, wa_data[base]}, 32'h0002);

        // start held high through LOAD, FINAL and the ready-pulse cycle.
        seq.delete();
        for (int i = 0; i < 20; i++) seq.push_back(2'($urandom_range(0, 3)));
        run_load("s6", 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls beyond its bounds.
    initial begin
        #500000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
